// File: rtl/axi_lite_bus_arbiter.sv
// axi_lite_bus_arbiter
//   Shares one AXI-lite master port between two requesters: port 0 is
//   instruction fetch and port 1 is the load/store unit. Only one transaction
//   is in flight at a time. The block sequences AR/R for reads and AW/W/B for
//   writes, then returns read data or a write acknowledge to the granted port.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : on a tie, grant the port that was not granted
//                                   last (the last-grant flop resets to port 1)
//                       undefined : fixed priority, port 1 wins a tie
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   req_valid/ready/write   per-port request handshake and direction (bit i = port i)
//   req_addr/wdata/wstrb    per-port request fields (port i at [i*32 +: 32] / [i*4 +: 4])
//   rsp_valid/rdata/err     one-cycle completion pulse, read data and error flag
//   aw*/w*/b*/ar*/r*        AXI-lite master channels
module axi_lite_bus_arbiter #(
  parameter logic [2:0] PROT_FETCH = 3'b100,
  parameter logic [2:0] PROT_DATA  = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddress,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddress,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_RSP
  } state_t;

  state_t      state_q;
  logic        grant_q;
  logic        grant_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_q;
`endif

  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [31:0] awaddress_q, wdata_q, araddress_q;
  logic [2:0]  awprot_q, arprot_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        sel_write;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [2:0]  sel_prot;
  logic        aw_done, w_done;

  // Winner among the currently valid requests.
  always_comb begin
    grant_d = 1'b0;
    case (req_valid)
      2'b01:   grant_d = 1'b0;
      2'b10:   grant_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11:   grant_d = ~last_q;
`else
      2'b11:   grant_d = 1'b1;
`endif
      default: grant_d = 1'b0;
    endcase
  end

  always_comb begin
    sel_write = grant_d ? req_write[1]     : req_write[0];
    sel_addr  = grant_d ? req_addr[63:32]  : req_addr[31:0];
    sel_wdata = grant_d ? req_wdata[63:32] : req_wdata[31:0];
    sel_wstrb = grant_d ? req_wstrb[7:4]   : req_wstrb[3:0];
    sel_prot  = grant_d ? PROT_DATA        : PROT_FETCH;
  end

  // Accept pulse is combinational so the requester sees it in the same cycle.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && (|req_valid)) begin
      req_ready[grant_d] = 1'b1;
    end
  end

  // AW and W complete independently; a channel is done once its valid has dropped
  // or it is handshaking in this cycle.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddress_q <= '0;
      wdata_q     <= '0;
      araddress_q <= '0;
      awprot_q    <= '0;
      arprot_q    <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= grant_d;
`endif
            if (sel_write) begin
              awvalid_q   <= 1'b1;
              wvalid_q    <= 1'b1;
              awaddress_q <= sel_addr;
              awprot_q    <= sel_prot;
              wdata_q     <= sel_wdata;
              wstrb_q     <= sel_wstrb;
              state_q     <= S_WR;
            end else begin
              arvalid_q   <= 1'b1;
              araddress_q <= sel_addr;
              arprot_q    <= sel_prot;
              state_q     <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            rsp_rdata_q <= rdata;
            rsp_err_q   <= |rresp;
            state_q     <= S_RSP;
          end
        end
        S_WR: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            rsp_rdata_q <= '0;
            rsp_err_q   <= |bresp;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign awvalid   = awvalid_q;
  assign awaddress = awaddress_q;
  assign awprot    = awprot_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddress = araddress_q;
  assign arprot    = arprot_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_axi_lite_bus_arbiter.sv
// tb_axi_lite_bus_arbiter
//   Self-checking bench for axi_lite_bus_arbiter. A behavioural AXI-lite slave
//   with per-channel wait knobs answers the DUT; expected responses are queued
//   when a request is driven and compared when rsp_valid pulses.
module tb_axi_lite_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddress, wdata, araddress, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_lite_bus_arbiter #(.PROT_FETCH(3'b100), .PROT_DATA(3'b000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Slave knobs
  int unsigned ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int unsigned ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic        slv_fixed_en = 1'b0;
  logic [31:0] slv_fixed = '0;
  logic [1:0]  slv_rresp = '0, slv_bresp = '0;
  logic [31:0] ar_addr_cap = '0;

  // Behavioural slave: outputs updated just after each rising edge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    forever begin
      @(posedge clk); #1;
      if (arvalid) begin
        arready = (ar_cnt >= ar_wait);
        if (arready) ar_addr_cap = araddress; else ar_cnt++;
      end else begin
        arready = 1'b0; ar_cnt = 0;
      end
      if (rready) begin
        if (r_cnt >= r_wait) begin
          rvalid = 1'b1;
          rdata  = slv_fixed_en ? slv_fixed : (ar_addr_cap ^ 32'h5A5A0000);
          rresp  = slv_rresp;
        end else begin
          rvalid = 1'b0; r_cnt++;
        end
      end else begin
        rvalid = 1'b0; rdata = '0; rresp = '0; r_cnt = 0;
      end
      if (awvalid) begin
        awready = (aw_cnt >= aw_wait);
        if (!awready) aw_cnt++;
      end else begin
        awready = 1'b0; aw_cnt = 0;
      end
      if (wvalid) begin
        wready = (w_cnt >= w_wait);
        if (!wready) w_cnt++;
      end else begin
        wready = 1'b0; w_cnt = 0;
      end
      if (bready) begin
        if (b_cnt >= b_wait) begin
          bvalid = 1'b1; bresp = slv_bresp;
        end else begin
          bvalid = 1'b0; b_cnt++;
        end
      end else begin
        bvalid = 1'b0; bresp = '0; b_cnt = 0;
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b, none expected", rsp_valid);
        end else begin
          mon_e = exp_q.pop_front();
          if (rsp_valid !== mon_e.port) begin
            errors++;
            $display("FAIL rsp_port: got %b expected %b", rsp_valid, mon_e.port);
          end
          checks++;
          if (rsp_rdata !== mon_e.rdata) begin
            errors++;
            $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, mon_e.rdata);
          end
          checks++;
          if (rsp_err !== mon_e.err) begin
            errors++;
            $display("FAIL rsp_err: got %b expected %b", rsp_err, mon_e.err);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[p]         = w;
    req_addr[p*32 +: 32] = a;
    req_wdata[p*32 +: 32] = d;
    req_wstrb[p*4 +: 4]  = s;
  endtask

  task automatic push_exp(input logic [1:0] port, input logic [31:0] d, input logic e);
    exp_t x;
    x.port = port; x.rdata = d; x.err = e;
    exp_q.push_back(x);
  endtask

  // Waits for all queued responses, then realigns to just after a rising edge.
  task automatic wait_drain();
    int n;
    for (n = 0; n < 60; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_write = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err, req_ready});
    end
    checks++;
    if ({araddress, awaddress, wdata, wstrb, arprot, awprot, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {araddress, awaddress, wdata, wstrb, arprot, awprot, rsp_rdata});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    ar_wait = 0; r_wait = 0; slv_fixed_en = 1'b1; slv_fixed = 32'hDEADBEEF; slv_rresp = 2'b00;
    set_req(0, 1'b0, 32'h100, 32'h0, 4'h0);
    req_valid = 2'b01;
    push_exp(2'b01, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_accept: got %b expected 01", req_ready); end
    tick(); req_valid = '0;
    @(negedge clk);
    checks++;
    if ({arvalid, araddress, arprot} !== {1'b1, 32'h100, 3'b100}) begin
      errors++;
      $display("FAIL rd_ar: got %b/%h/%b expected 1/00000100/100", arvalid, araddress, arprot);
    end
    tick(); @(negedge clk);
    checks++;
    if (rready !== 1'b1) begin errors++; $display("FAIL rd_rready: got %b expected 1", rready); end
    tick(); @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_latency: rsp_valid@3=%b expected 01", rsp_valid); end
    wait_drain();
    slv_fixed_en = 1'b0;
  endtask

  task automatic test_write();
    aw_wait = 2; w_wait = 0; b_wait = 0; slv_bresp = 2'b10;
    set_req(1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
    req_valid = 2'b10;
    push_exp(2'b10, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_accept: got %b expected 10", req_ready); end
    tick(); req_valid = '0;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, awaddress, wdata, wstrb, awprot} !==
        {2'b11, 32'h200, 32'h12345678, 4'b0011, 3'b000}) begin
      errors++;
      $display("FAIL wr_aw_w: got %b%b/%h/%h/%b/%b expected 11/00000200/12345678/0011/000",
               awvalid, wvalid, awaddress, wdata, wstrb, awprot);
    end
    tick(); @(negedge clk);
    checks++;
    if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL wr_w_first: got %b expected 10", {awvalid, wvalid}); end
    tick(); @(negedge clk);
    checks++;
    if ({awvalid, wvalid, awaddress} !== {2'b10, 32'h200}) begin
      errors++;
      $display("FAIL wr_aw_hold: got %b/%h expected 10/00000200", {awvalid, wvalid}, awaddress);
    end
    tick(); @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr_b: got %b expected 001", {awvalid, wvalid, bready}); end
    tick(); @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b10) begin errors++; $display("FAIL wr_rsp_cycle: got %b expected 10", rsp_valid); end
    wait_drain();
    aw_wait = 0; slv_bresp = 2'b00;
  endtask

  task automatic test_stall();
    ar_wait = 5;
    set_req(0, 1'b0, 32'h440, 32'h0, 4'h0);
    req_valid = 2'b01;
    push_exp(2'b01, 32'h440 ^ 32'h5A5A0000, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL st_accept: got %b expected 01", req_ready); end
    tick();
    set_req(1, 1'b0, 32'h999, 32'h0, 4'h0);
    req_valid = 2'b10;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if ({arvalid, araddress, req_ready} !== {1'b1, 32'h440, 2'b00}) begin
        errors++;
        $display("FAIL st_hold%0d: got %b/%h/%b expected 1/00000440/00", i, arvalid, araddress, req_ready);
      end
      tick();
    end
    req_valid = '0;
    wait_drain();
    ar_wait = 0;
  endtask

  task automatic test_tie();
    int first, p, acc[2];
    logic [1:0] oh;
    bit got;
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
`ifdef ARB_ROUND_ROBIN_EN
    first = 0;
`else
    first = 1;
`endif
    for (int r = 0; r < 4; r++) begin
      set_req(0, 1'b0, 32'h300 + r * 16, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h304 + r * 16, 32'h0, 4'h0);
      req_valid = 2'b11;
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? first : 1 - first;
        oh = (p == 0) ? 2'b01 : 2'b10;
        push_exp(oh, (32'h300 + r * 16 + p * 4) ^ 32'h5A5A0000, 1'b0);
      end
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? first : 1 - first;
        oh = (p == 0) ? 2'b01 : 2'b10;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
          @(negedge clk);
          if (req_ready !== 2'b00) begin got = 1'b1; break; end
        end
        acc[k] = cyc;
        checks++;
        if (!got || req_ready !== oh) begin
          errors++;
          $display("FAIL tie_grant r%0d k%0d: got %b expected %b", r, k, req_ready, oh);
        end
        tick();
        req_valid[p] = 1'b0;
      end
      checks++;
      if (acc[1] - acc[0] != 4) begin
        errors++;
        $display("FAIL tie_b2b r%0d: accept gap %0d expected 4", r, acc[1] - acc[0]);
      end
      req_valid = '0;
      wait_drain();
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    r_wait = 20;
    set_req(0, 1'b0, 32'h500, 32'h0, 4'h0);
    req_valid = 2'b01;
    push_exp(2'b01, 32'h0, 1'b0);
    @(negedge clk);
    tick(); req_valid = '0;
    tick(); @(negedge clk);
    checks++;
    if (rready !== 1'b1) begin errors++; $display("FAIL rm_in_r: rready=%b expected 1", rready); end
    tick(); reset = 1'b1;
    tick(); @(negedge clk);
    exp_q.delete();
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err, araddress, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL rm_outputs: got %h expected 0",
               {arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err, araddress, rsp_rdata});
    end
    tick(); reset = 1'b0; r_wait = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_no_rsp%0d: got %b expected 00", i, rsp_valid); end
      tick();
    end
    set_req(0, 1'b0, 32'h600, 32'h0, 4'h0);
    req_valid = 2'b01;
    push_exp(2'b01, 32'h600 ^ 32'h5A5A0000, 1'b0);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready === 2'b01) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rm_reaccept: req_ready=%b expected 01", req_ready); end
    tick(); req_valid = '0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_tie();
    test_reset_mid();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
